// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator: one register read or write per command, response returned on rsp port.
// Optional watchdog enabled by AXIL_CFG_MASTER_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_cfg_master #(
   parameter int AXIL_DATA_WIDTH = 64,
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int REG_IDX_WIDTH   = 4,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [REG_IDX_WIDTH-1:0]     cmd_idx,
   input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_write,
   output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                   rsp_resp,
   output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
   output logic [2:0]                   m_axil_awprot,
   output logic                         m_axil_awvalid,
   input  logic                         m_axil_awready,
   output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
   output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
   output logic                         m_axil_wvalid,
   input  logic                         m_axil_wready,
   input  logic [1:0]                   m_axil_bresp,
   input  logic                         m_axil_bvalid,
   output logic                         m_axil_bready,
   output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
   output logic [2:0]                   m_axil_arprot,
   output logic                         m_axil_arvalid,
   input  logic                         m_axil_arready,
   input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
   input  logic [1:0]                   m_axil_rresp,
   input  logic                         m_axil_rvalid,
   output logic                         m_axil_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_B,
      RD_AR,
      RD_R,
      RSP
   } state_t;

   state_t                       state_q;
   logic [AXIL_ADDR_WIDTH-1:0]   awaddr_q;
   logic [AXIL_ADDR_WIDTH-1:0]   araddr_q;
   logic [AXIL_DATA_WIDTH-1:0]   wdata_q;
   logic                         awvalid_q;
   logic                         wvalid_q;
   logic                         bready_q;
   logic                         arvalid_q;
   logic                         rready_q;
   logic                         aw_done_q;
   logic                         w_done_q;
   logic                         rsp_valid_q;
   logic                         rsp_write_q;
   logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]                   rsp_resp_q;

   logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr_d;
   logic                         aw_done_d;
   logic                         w_done_d;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q;
   logic          busy_d;
`endif

   // Register n lives at byte address 8n (64-bit stride).
   always_comb begin
      cmd_addr_d = '0;
      cmd_addr_d[REG_IDX_WIDTH+2:0] = {cmd_idx, 3'b000};
   end

   assign aw_done_d = aw_done_q | (awvalid_q & m_axil_awready);
   assign w_done_d  = w_done_q  | (wvalid_q  & m_axil_wready);

   assign cmd_ready      = (state_q == IDLE);
   assign rsp_valid      = rsp_valid_q;
   assign rsp_write      = rsp_write_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_resp       = rsp_resp_q;
   assign m_axil_awaddr  = awaddr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = '1;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = bready_q;
   assign m_axil_araddr  = araddr_q;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = rready_q;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
   assign busy_d = (state_q == WR) || (state_q == WR_B) ||
                   (state_q == RD_AR) || (state_q == RD_R);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  rsp_write_q <= cmd_write;
                  if (cmd_write) begin
                     awaddr_q  <= cmd_addr_d;
                     wdata_q   <= cmd_wdata;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= WR;
                  end else begin
                     araddr_q  <= cmd_addr_d;
                     arvalid_q <= 1'b1;
                     state_q   <= RD_AR;
                  end
               end
            end
            WR: begin
               // AW and W retire independently, in any order.
               if (awvalid_q && m_axil_awready) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (wvalid_q && m_axil_wready) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if (aw_done_d && w_done_d) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  bready_q  <= 1'b1;
                  state_q   <= WR_B;
               end
            end
            WR_B: begin
               if (m_axil_bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= m_axil_bresp;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RD_AR: begin
               if (m_axil_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_R;
               end
            end
            RD_R: begin
               if (m_axil_rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_resp_q  <= m_axil_rresp;
                  rsp_rdata_q <= m_axil_rdata;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
         // Watchdog wins over any handshake landing on its final cycle.
         if (state_q == IDLE) begin
            tmo_q <= '0;
         end else if (busy_d) begin
            if (tmo_q == TMO_LAST) begin
               awvalid_q   <= 1'b0;
               wvalid_q    <= 1'b0;
               bready_q    <= 1'b0;
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               aw_done_q   <= 1'b0;
               w_done_q    <= 1'b0;
               rsp_resp_q  <= 2'b11;
               rsp_rdata_q <= '0;
               rsp_valid_q <= 1'b1;
               state_q     <= RSP;
            end else begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: cycle-level AXI-Lite slave plus register-file reference model.
`timescale 1ns/1ps
module tb_axil_cfg_master;

   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int IW  = 4;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [IW-1:0] cmd_idx;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] awaddr;
   logic [2:0]    awprot;
   logic          awvalid;
   logic          awready;
   logic [DW-1:0] wdata;
   logic [7:0]    wstrb;
   logic          wvalid;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;

   always #5 clk = ~clk;

   axil_cfg_master #(
      .AXIL_DATA_WIDTH(DW),
      .AXIL_ADDR_WIDTH(AW),
      .REG_IDX_WIDTH  (IW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_write     (cmd_write),
      .cmd_idx       (cmd_idx),
      .cmd_wdata     (cmd_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_write     (rsp_write),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .m_axil_awaddr (awaddr),
      .m_axil_awprot (awprot),
      .m_axil_awvalid(awvalid),
      .m_axil_awready(awready),
      .m_axil_wdata  (wdata),
      .m_axil_wstrb  (wstrb),
      .m_axil_wvalid (wvalid),
      .m_axil_wready (wready),
      .m_axil_bresp  (bresp),
      .m_axil_bvalid (bvalid),
      .m_axil_bready (bready),
      .m_axil_araddr (araddr),
      .m_axil_arprot (arprot),
      .m_axil_arvalid(arvalid),
      .m_axil_arready(arready),
      .m_axil_rdata  (rdata),
      .m_axil_rresp  (rresp),
      .m_axil_rvalid (rvalid),
      .m_axil_rready (rready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference register file (command view) and slave storage (bus view)
   logic [DW-1:0] mdl_mem [16];
   logic [DW-1:0] sl_mem  [16];

   int aw_dly, w_dly, b_dly, ar_dly, r_dly;
   int aw_n, w_n, b_n, ar_n, r_n;
   int aw_hs, w_hs, b_hs, ar_hs, r_hs;
   bit b_took, r_took;
   int bad_pay;
   logic [1:0]    sl_resp;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata;
   logic [AW-1:0] aw_cap, ar_cap;
   logic [DW-1:0] w_cap;

   task automatic slave_reset();
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      b_took = 0; r_took = 0; bad_pay = 0;
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = '0;
   endtask

   // Called at each negedge; a handshake is logged when both sides
   // will be high at the coming posedge.
   task automatic slave_step();
      if (b_took) bvalid = 0;
      else if (aw_hs > 0 && w_hs > 0) begin
         b_n++;
         if (b_n > b_dly) begin
            bvalid = 1;
            bresp = sl_resp;
            if (bready) begin
               b_took = 1;
               b_hs++;
               sl_mem[aw_cap[6:3]] = w_cap;
            end
         end
      end
      if (r_took) rvalid = 0;
      else if (ar_hs > 0) begin
         r_n++;
         if (r_n > r_dly) begin
            rvalid = 1;
            rdata = sl_mem[ar_cap[6:3]];
            rresp = sl_resp;
            if (rready) begin
               r_took = 1;
               r_hs++;
            end
         end
      end
      awready = 0;
      if (awvalid) begin
         aw_n++;
         if (awaddr !== exp_addr || awprot !== 3'b000) bad_pay++;
         if (aw_n >= aw_dly) begin
            awready = 1;
            aw_hs++;
            aw_cap = awaddr;
         end
      end
      wready = 0;
      if (wvalid) begin
         w_n++;
         if (wdata !== exp_wdata || wstrb !== 8'hFF) bad_pay++;
         if (w_n >= w_dly) begin
            wready = 1;
            w_hs++;
            w_cap = wdata;
         end
      end
      arready = 0;
      if (arvalid) begin
         ar_n++;
         if (araddr !== exp_addr || arprot !== 3'b000) bad_pay++;
         if (ar_n >= ar_dly) begin
            arready = 1;
            ar_hs++;
            ar_cap = araddr;
         end
      end
   endtask

   task automatic run_txn(input bit wr, input int idx, input logic [DW-1:0] data,
                          input int d1, input int d2, input int d3,
                          input int rspd, input logic [1:0] resp,
                          input bit rst_wrb);
      logic [DW-1:0] exp_rdata;
      logic [DW-1:0] snap_data;
      logic [1:0]    snap_resp;
      logic          snap_wr;
      int cyc, rsp_n, stale, crdy_bad;
      bit done, took;
      slave_reset();
      check("cmd_ready_idle", cmd_ready, 1);
      exp_addr  = AW'(idx * 8);
      exp_wdata = data;
      sl_resp   = resp;
      exp_rdata = wr ? '0 : mdl_mem[idx];
      if (wr) begin
         aw_dly = d1; w_dly = d2; b_dly = d3; ar_dly = 0; r_dly = 0;
      end else begin
         ar_dly = d1; r_dly = d2; aw_dly = 0; w_dly = 0; b_dly = 0;
      end
      cmd_valid = 1; cmd_write = wr;
      cmd_idx = IW'(idx); cmd_wdata = data;
      cyc = 0; rsp_n = 0; stale = 0; crdy_bad = 0;
      done = 0; took = 0;
      snap_data = '0; snap_resp = 0; snap_wr = 0;
      while (!done && cyc < 300) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         cmd_valid = 0;
         cmd_wdata = {$urandom, $urandom};
         if (rst_wrb && bready) begin
            rst = 1;
            @(posedge clk);
            @(negedge clk);
            rst = 0;
            slave_reset();
            check("rst_awvalid", awvalid, 0);
            check("rst_wvalid", wvalid, 0);
            check("rst_arvalid", arvalid, 0);
            check("rst_bready", bready, 0);
            check("rst_rready", rready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            return;
         end
         slave_step();
         if (took) begin
            rsp_ready = 0;
            done = 1;
            check("rsp_drop", rsp_valid, 0);
            check("cmd_ready_after", cmd_ready, 1);
         end else if (rsp_valid) begin
            if (rsp_n == 0) begin
               snap_wr = rsp_write; snap_data = rsp_rdata; snap_resp = rsp_resp;
               check("rsp_write", rsp_write, wr);
               check("rsp_rdata", rsp_rdata, exp_rdata);
               check("rsp_resp", rsp_resp, resp);
            end else if (rsp_write !== snap_wr || rsp_rdata !== snap_data ||
                         rsp_resp !== snap_resp) stale++;
            if (cmd_ready) crdy_bad++;
            rsp_n++;
            if (rsp_n > rspd) begin
               rsp_ready = 1;
               took = 1;
            end
         end
      end
      check("txn_done", done, 1);
      check("rsp_hold_cycles", rsp_n, rspd + 1);
      check("rsp_stable", stale, 0);
      check("cmd_ready_in_rsp", crdy_bad, 0);
      check("payload_stable", bad_pay, 0);
      if (wr) begin
         mdl_mem[idx] = data;
         check("aw_hs", aw_hs, 1);
         check("w_hs", w_hs, 1);
         check("b_hs", b_hs, 1);
         check("ar_hs_wr", ar_hs, 0);
         check("awvalid_cycles", aw_n, d1);
         check("wvalid_cycles", w_n, d2);
         check("awaddr", aw_cap, exp_addr);
         check("wdata", w_cap, data);
      end else begin
         check("ar_hs", ar_hs, 1);
         check("r_hs", r_hs, 1);
         check("aw_hs_rd", aw_hs, 0);
         check("arvalid_cycles", ar_n, d1);
         check("araddr", ar_cap, exp_addr);
      end
   endtask

   initial begin
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_idx = '0; cmd_wdata = '0;
      rsp_ready = 0;
      for (int i = 0; i < 16; i++) begin
         mdl_mem[i] = '0;
         sl_mem[i]  = '0;
      end
      slave_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_awvalid", awvalid, 0);
      check("reset_wvalid", wvalid, 0);
      check("reset_arvalid", arvalid, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_awaddr", awaddr, 0);
      check("reset_araddr", araddr, 0);
      check("reset_wdata", wdata, 0);
      check("reset_wstrb", wstrb, 8'hFF);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_rsp_resp", rsp_resp, 0);
      rst = 0;
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1);

      run_txn(1, 1, {29'd1, 3'd0, 32'd64}, 1, 1, 0, 0, 2'b00, 0);
      run_txn(1, 3, 64'hDEAD_BEEF_0123_4567, 3, 1, 0, 0, 2'b00, 0);
      mdl_mem[2] = 64'h0000_0064_0000_0320;
      sl_mem[2]  = 64'h0000_0064_0000_0320;
      run_txn(0, 2, '0, 1, 2, 0, 0, 2'b00, 0);
      run_txn(0, 1, '0, 2, 0, 0, 5, 2'b00, 0);
      run_txn(1, 7, 64'h1111_2222_3333_4444, 1, 2, 50, 0, 2'b00, 1);
      run_txn(0, 7, '0, 1, 0, 0, 0, 2'b10, 0);
      run_txn(1, 15, 64'hFFFF_0000_FFFF_0000, 1, 3, 1, 1, 2'b10, 0);

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
      begin
         int cyc, t_rise;
         bit seen;
         slave_reset();
         exp_addr = AW'(5 * 8);
         ar_dly = 100000; r_dly = 0;
         cmd_valid = 1; cmd_write = 0; cmd_idx = IW'(5);
         cyc = 0; t_rise = -1; seen = 0;
         while (!seen && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            cmd_valid = 0;
            if (arvalid && t_rise < 0) t_rise = cyc;
            if (rsp_valid) begin
               seen = 1;
               check("tmo_latency", cyc - t_rise, TMO);
               check("tmo_arvalid", arvalid, 0);
               check("tmo_resp", rsp_resp, 2'b11);
               check("tmo_rdata", rsp_rdata, 0);
            end else slave_step();
         end
         check("tmo_seen", seen, 1);
         rsp_ready = 1;
         @(posedge clk);
         @(negedge clk);
         rsp_ready = 0;
         check("tmo_cmd_ready", cmd_ready, 1);
      end
`endif

      for (int t = 0; t < 40; t++) begin
         bit wr;
         int idx;
         wr  = bit'($urandom_range(0, 1));
         idx = int'($urandom_range(0, 15));
         run_txn(wr, idx, {$urandom, $urandom},
                 int'($urandom_range(1, 4)), int'($urandom_range(wr ? 1 : 0, 4)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
